reg_targetio_ctrl: RTL and testbench



---
 rtl/reg_targetio_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_reg_targetio_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_targetio_ctrl.sv
// reg_targetio_ctrl
// Register-mapped controller for NCH target IO channels on the shared
// register bus. Each channel has a mode byte that selects high-Z, fixed drive,
// passthrough of one of NSRC sources, or open-drain. Pad inputs are
// synchronised and produce sticky change flags. Pad drive is gated by a
// sequenced target-power state machine.
//
// Ports:
//   clk            register/interface clock
//   reset_n        asynchronous active-low reset
//   reg_address    register address (6 bits)
//   reg_bytecnt    byte index within the addressed register
//   reg_datai      write data byte
//   reg_datao      read data byte, 0 when this block is not addressed
//   reg_read       read strobe
//   reg_write      write strobe
//   reg_addrvalid  address-valid qualifier
//   reg_hypaddress length-query address
//   reg_hyplen     length in bytes of reg_hypaddress, 0 if not ours
//   src_i          passthrough sources
//   io_in          pad input values
//   io_out         pad output values (registered)
//   io_oe          pad output enables (registered)
//   target_npower  0 = target powered (registered)
//   edge_any       OR of all sticky change flags (registered)
//
// Register map:
//   ADDR_MODE  byte c: [2:0] mode, [5:3] source index, [7:6] read as 0
//   ADDR_STATE synchronised input state, read-only
//   ADDR_EDGE  sticky change flags, write 1 to clear
//   ADDR_PWR   bit0 power request, bits 2:1 power FSM state (read-only)

module reg_targetio_ctrl #(
  parameter int NCH        = 8,
  parameter int NSRC       = 4,
  parameter int ADDR_MODE  = 56,
  parameter int ADDR_STATE = 57,
  parameter int ADDR_EDGE  = 58,
  parameter int ADDR_PWR   = 59,
  parameter int PWR_DELAY  = 1000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [5:0]      reg_address,
  input  logic [15:0]     reg_bytecnt,
  input  logic [7:0]      reg_datai,
  output logic [7:0]      reg_datao,
  input  logic            reg_read,
  input  logic            reg_write,
  input  logic            reg_addrvalid,
  input  logic [5:0]      reg_hypaddress,
  output logic [15:0]     reg_hyplen,
  input  logic [NSRC-1:0] src_i,
  input  logic [NCH-1:0]  io_in,
  output logic [NCH-1:0]  io_out,
  output logic [NCH-1:0]  io_oe,
  output logic            target_npower,
  output logic            edge_any
);

  localparam int NB   = (NCH + 7) / 8;
  localparam int CNTW = $clog2(PWR_DELAY) + 1;

  localparam logic [5:0] A_MODE  = 6'(ADDR_MODE);
  localparam logic [5:0] A_STATE = 6'(ADDR_STATE);
  localparam logic [5:0] A_EDGE  = 6'(ADDR_EDGE);
  localparam logic [5:0] A_PWR   = 6'(ADDR_PWR);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(PWR_DELAY - 1);

  typedef enum logic [1:0] {
    PWR_OFF      = 2'd0,
    PWR_ON_WAIT  = 2'd1,
    PWR_ON       = 2'd2,
    PWR_OFF_WAIT = 2'd3
  } pwr_state_t;

  // Selected source value; an index with no matching source yields 0.
  function automatic logic src_sel(input logic [NSRC-1:0] src, input logic [2:0] idx);
    logic v;
    v = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      v = v | (src[i] & (idx == 3'(i)));
    end
    return v;
  endfunction

  // Pad drive for one channel as {oe, out}; undefined modes are high-Z.
  function automatic logic [1:0] pad_drive(input logic [2:0] mode, input logic s);
    logic [1:0] d;
    case (mode)
      3'd1:    d = 2'b10;
      3'd2:    d = 2'b11;
      3'd3:    d = {1'b1, s};
      3'd4:    d = {~s, 1'b0};
      default: d = 2'b00;
    endcase
    return d;
  endfunction

  logic [5:0]      mode_r [NCH];
  logic [5:0]      mode_nxt_s [NCH];
  logic            req_r;
  logic            req_nxt_s;
  logic [NCH-1:0]  sync1_r;
  logic [NCH-1:0]  sync_r;
  logic [NCH-1:0]  prev_r;
  logic [NCH-1:0]  flag_r;
  logic [NCH-1:0]  flag_nxt_s;
  logic [NCH-1:0]  set_s;
  logic [NCH-1:0]  clr_s;
  logic [NB*8-1:0] clr_pad_s;
  logic [NB*8-1:0] state_pad_s;
  logic [NB*8-1:0] flag_pad_s;
  logic            edge_any_r;
  pwr_state_t      state_r;
  logic [CNTW-1:0] cnt_r;
  logic            npower_r;
  logic [NCH-1:0]  io_out_r;
  logic [NCH-1:0]  io_oe_r;
  logic [NCH-1:0]  oe_mode_s;
  logic [NCH-1:0]  out_mode_s;
  logic [7:0]      rdata_s;
  logic            wr_mode_s;
  logic            wr_edge_s;
  logic            wr_pwr_s;
  logic            rd_en_s;

  assign wr_mode_s = reg_write && reg_addrvalid && (reg_address == A_MODE);
  assign wr_edge_s = reg_write && reg_addrvalid && (reg_address == A_EDGE);
  assign wr_pwr_s  = reg_write && reg_addrvalid && (reg_address == A_PWR);
  assign rd_en_s   = reg_read && reg_addrvalid;

  // Mode bytes as they will be after this cycle's write, so pad outputs
  // reflect a mode write one cycle later.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      if (wr_mode_s && (reg_bytecnt == 16'(c))) begin
        mode_nxt_s[c] = reg_datai[5:0];
      end else begin
        mode_nxt_s[c] = mode_r[c];
      end
    end
  end

  // Power request as it will be after this cycle's write.
  always_comb begin
    if (wr_pwr_s && (reg_bytecnt == 16'd0)) begin
      req_nxt_s = reg_datai[0];
    end else begin
      req_nxt_s = req_r;
    end
  end

  // Per-channel pad drive requested by the mode, before power gating.
  always_comb begin
    oe_mode_s  = '0;
    out_mode_s = '0;
    for (int c = 0; c < NCH; c++) begin
      {oe_mode_s[c], out_mode_s[c]} =
        pad_drive(mode_nxt_s[c][2:0], src_sel(src_i, mode_nxt_s[c][5:3]));
    end
  end

  // Sticky flag update: a change sets, a written 1 clears, set wins.
  always_comb begin
    clr_pad_s = '0;
    for (int b = 0; b < NB; b++) begin
      clr_pad_s[b*8 +: 8] = (wr_edge_s && (reg_bytecnt == 16'(b))) ? reg_datai : 8'h00;
    end
    clr_s      = clr_pad_s[NCH-1:0];
    set_s      = sync_r ^ prev_r;
    flag_nxt_s = (flag_r & ~clr_s) | set_s;
  end

  // Mode byte and power request storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        mode_r[c] <= 6'd0;
      end
      req_r <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        mode_r[c] <= mode_nxt_s[c];
      end
      req_r <= req_nxt_s;
    end
  end

  // Input synchroniser, previous-value flop and sticky change flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r    <= '0;
      sync_r     <= '0;
      prev_r     <= '0;
      flag_r     <= '0;
      edge_any_r <= 1'b0;
    end else begin
      sync1_r    <= io_in;
      sync_r     <= sync1_r;
      prev_r     <= sync_r;
      flag_r     <= flag_nxt_s;
      edge_any_r <= |flag_nxt_s;
    end
  end

  // Target power sequencer; pad outputs are driven only while in ON and are
  // loaded with the state transition so they change on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= PWR_OFF;
      cnt_r    <= '0;
      npower_r <= 1'b1;
      io_oe_r  <= '0;
      io_out_r <= '0;
    end else begin
      case (state_r)
        PWR_OFF: begin
          cnt_r    <= '0;
          io_oe_r  <= '0;
          io_out_r <= '0;
          if (req_nxt_s) begin
            state_r  <= PWR_ON_WAIT;
            npower_r <= 1'b0;
          end else begin
            state_r  <= PWR_OFF;
            npower_r <= 1'b1;
          end
        end
        PWR_ON_WAIT: begin
          if (!req_nxt_s) begin
            state_r  <= PWR_OFF;
            cnt_r    <= '0;
            npower_r <= 1'b1;
            io_oe_r  <= '0;
            io_out_r <= '0;
          end else if (cnt_r == CNT_LAST) begin
            state_r  <= PWR_ON;
            cnt_r    <= '0;
            npower_r <= 1'b0;
            io_oe_r  <= oe_mode_s;
            io_out_r <= out_mode_s;
          end else begin
            state_r  <= PWR_ON_WAIT;
            cnt_r    <= cnt_r + 1'b1;
            npower_r <= 1'b0;
            io_oe_r  <= '0;
            io_out_r <= '0;
          end
        end
        PWR_ON: begin
          cnt_r    <= '0;
          npower_r <= 1'b0;
          if (!req_nxt_s) begin
            state_r  <= PWR_OFF_WAIT;
            io_oe_r  <= '0;
            io_out_r <= '0;
          end else begin
            state_r  <= PWR_ON;
            io_oe_r  <= oe_mode_s;
            io_out_r <= out_mode_s;
          end
        end
        PWR_OFF_WAIT: begin
          // Request changes are deliberately ignored until OFF is reached.
          io_oe_r  <= '0;
          io_out_r <= '0;
          if (cnt_r == CNT_LAST) begin
            state_r  <= PWR_OFF;
            cnt_r    <= '0;
            npower_r <= 1'b1;
          end else begin
            state_r  <= PWR_OFF_WAIT;
            cnt_r    <= cnt_r + 1'b1;
            npower_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= PWR_OFF;
          cnt_r    <= '0;
          npower_r <= 1'b1;
          io_oe_r  <= '0;
          io_out_r <= '0;
        end
      endcase
    end
  end

  // Read-data mux; bits beyond NCH and bytes beyond a register's length read 0.
  always_comb begin
    rdata_s     = 8'h00;
    state_pad_s = '0;
    flag_pad_s  = '0;
    state_pad_s[NCH-1:0] = sync_r;
    flag_pad_s[NCH-1:0]  = flag_r;
    if (rd_en_s && (reg_address == A_MODE)) begin
      for (int c = 0; c < NCH; c++) begin
        rdata_s = (reg_bytecnt == 16'(c)) ? {2'b00, mode_r[c]} : rdata_s;
      end
    end else if (rd_en_s && (reg_address == A_STATE)) begin
      for (int b = 0; b < NB; b++) begin
        rdata_s = (reg_bytecnt == 16'(b)) ? state_pad_s[b*8 +: 8] : rdata_s;
      end
    end else if (rd_en_s && (reg_address == A_EDGE)) begin
      for (int b = 0; b < NB; b++) begin
        rdata_s = (reg_bytecnt == 16'(b)) ? flag_pad_s[b*8 +: 8] : rdata_s;
      end
    end else if (rd_en_s && (reg_address == A_PWR)) begin
      rdata_s = (reg_bytecnt == 16'd0) ? {5'b00000, state_r, req_r} : 8'h00;
    end else begin
      rdata_s = 8'h00;
    end
  end

  // Register length lookup for the bus length query.
  always_comb begin
    if (reg_hypaddress == A_MODE) begin
      reg_hyplen = 16'(NCH);
    end else if ((reg_hypaddress == A_STATE) || (reg_hypaddress == A_EDGE)) begin
      reg_hyplen = 16'(NB);
    end else if (reg_hypaddress == A_PWR) begin
      reg_hyplen = 16'd1;
    end else begin
      reg_hyplen = 16'd0;
    end
  end

  assign reg_datao     = rdata_s;
  assign io_out        = io_out_r;
  assign io_oe         = io_oe_r;
  assign target_npower = npower_r;
  assign edge_any      = edge_any_r;

endmodule

// File: tb/tb_reg_targetio_ctrl.sv
module tb_reg_targetio_ctrl;

  localparam int D = 4;
  localparam logic [5:0] A_MODE  = 6'd56;
  localparam logic [5:0] A_STATE = 6'd57;
  localparam logic [5:0] A_EDGE  = 6'd58;
  localparam logic [5:0] A_PWR   = 6'd59;

  logic        clk;
  logic        reset_n;
  logic [5:0]  reg_address;
  logic [15:0] reg_bytecnt;
  logic [7:0]  reg_datai;
  logic [7:0]  reg_datao;
  logic        reg_read;
  logic        reg_write;
  logic        reg_addrvalid;
  logic [5:0]  reg_hypaddress;
  logic [15:0] reg_hyplen;
  logic [3:0]  src_i;
  logic [7:0]  io_in;
  logic [7:0]  io_out;
  logic [7:0]  io_oe;
  logic        target_npower;
  logic        edge_any;

  int checks;
  int failures;

  reg_targetio_ctrl #(
    .NCH(8), .NSRC(4), .ADDR_MODE(56), .ADDR_STATE(57),
    .ADDR_EDGE(58), .ADDR_PWR(59), .PWR_DELAY(D)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
    .reg_datai(reg_datai), .reg_datao(reg_datao),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
    .reg_hypaddress(reg_hypaddress), .reg_hyplen(reg_hyplen),
    .src_i(src_i), .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
    .target_npower(target_npower), .edge_any(edge_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pad behaviour from a mode byte and the source lines: {oe, out}.
  function automatic logic [1:0] pad_model(input logic [7:0] mb, input logic [3:0] src);
    int idx;
    logic s;
    idx = int'(mb[5:3]);
    s = (idx < 4) ? src[idx] : 1'b0;
    case (int'(mb[2:0]))
      1: return 2'b10;
      2: return 2'b11;
      3: return {1'b1, s};
      4: return {~s, 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [15:0] b, input logic [7:0] d);
    reg_address   = a;
    reg_bytecnt   = b;
    reg_datai     = d;
    reg_write     = 1'b1;
    reg_addrvalid = 1'b1;
    tick();
    reg_write     = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a, input logic [15:0] b, output logic [7:0] d);
    reg_address   = a;
    reg_bytecnt   = b;
    reg_read      = 1'b1;
    reg_addrvalid = 1'b1;
    #1;
    d = reg_datao;
    reg_read      = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  task automatic power_up;
    bus_write(A_PWR, 16'd0, 8'h01);
    repeat (D) tick();
  endtask

  task automatic power_down;
    bus_write(A_PWR, 16'd0, 8'h00);
    repeat (D) tick();
  endtask

  task automatic test_reset;
    logic [7:0] d;
    checks++; if (io_oe !== 8'h00) begin failures++; $display("FAIL reset_oe got=%h exp=00", io_oe); end
    checks++; if (io_out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", io_out); end
    checks++; if (target_npower !== 1'b1) begin failures++; $display("FAIL reset_npower got=%b exp=1", target_npower); end
    checks++; if (edge_any !== 1'b0) begin failures++; $display("FAIL reset_edge_any got=%b exp=0", edge_any); end
    checks++; if (reg_datao !== 8'h00) begin failures++; $display("FAIL reset_datao got=%h exp=00", reg_datao); end
    reset_n = 1'b1;
    tick();
    bus_read(A_PWR, 16'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_pwr_reg got=%h exp=00", d); end
  endtask

  task automatic test_reset_mid_on;
    logic [7:0] d;
    bus_write(A_MODE, 16'd0, 8'h02);
    power_up();
    checks++; if ({io_oe[0], io_out[0]} !== 2'b11) begin failures++; $display("FAIL midon_pre got=%b exp=11", {io_oe[0], io_out[0]}); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (io_oe !== 8'h00) begin failures++; $display("FAIL midon_oe got=%h exp=00", io_oe); end
    checks++; if (io_out !== 8'h00) begin failures++; $display("FAIL midon_out got=%h exp=00", io_out); end
    checks++; if (target_npower !== 1'b1) begin failures++; $display("FAIL midon_npower got=%b exp=1", target_npower); end
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    bus_read(A_MODE, 16'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL midon_mode_cleared got=%h exp=00", d); end
    bus_read(A_PWR, 16'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL midon_pwr_cleared got=%h exp=00", d); end
  endtask

  task automatic test_power;
    logic [7:0] d;
    logic exp_oe, exp_np;
    bus_write(A_MODE, 16'd0, 8'h02);
    bus_write(A_PWR, 16'd0, 8'h01);
    for (int k = 1; k <= D + 2; k++) begin
      if (k > 1) tick();
      exp_oe = (k >= 1 + D);
      checks++; if (target_npower !== 1'b0) begin failures++; $display("FAIL pwrup_npower k=%0d got=%b exp=0", k, target_npower); end
      checks++; if (io_oe[0] !== exp_oe) begin failures++; $display("FAIL pwrup_oe k=%0d got=%b exp=%b", k, io_oe[0], exp_oe); end
    end
    bus_read(A_PWR, 16'd0, d);
    checks++; if (d !== 8'h05) begin failures++; $display("FAIL pwrup_state got=%h exp=05", d); end
    bus_write(A_PWR, 16'd0, 8'h00);
    for (int k = 1; k <= D + 2; k++) begin
      if (k > 1) tick();
      exp_np = (k >= 1 + D);
      checks++; if (io_oe[0] !== 1'b0) begin failures++; $display("FAIL pwrdn_oe k=%0d got=%b exp=0", k, io_oe[0]); end
      checks++; if (target_npower !== exp_np) begin failures++; $display("FAIL pwrdn_npower k=%0d got=%b exp=%b", k, target_npower, exp_np); end
    end
  endtask

  task automatic test_passthru;
    logic [7:0] d;
    logic [3:0] old_src, new_src;
    power_up();
    bus_write(A_MODE, 16'd2, 8'h1B);
    bus_read(A_MODE, 16'd2, d);
    checks++; if (d !== 8'h1B) begin failures++; $display("FAIL pt_mode_rd got=%h exp=1b", d); end
    checks++; if (io_oe[2] !== 1'b1) begin failures++; $display("FAIL pt_oe got=%b exp=1", io_oe[2]); end
    for (int i = 0; i < 8; i++) begin
      old_src = src_i;
      new_src = 4'($urandom);
      new_src[3] = ~old_src[3];
      src_i = new_src;
      #1;
      checks++; if (io_out[2] !== old_src[3]) begin failures++; $display("FAIL pt_lag got=%b exp=%b", io_out[2], old_src[3]); end
      tick();
      checks++; if (io_out[2] !== new_src[3]) begin failures++; $display("FAIL pt_follow got=%b exp=%b", io_out[2], new_src[3]); end
    end
    bus_write(A_MODE, 16'd2, 8'hFB);
    bus_read(A_MODE, 16'd2, d);
    checks++; if (d !== 8'h3B) begin failures++; $display("FAIL pt_reserved_rd got=%h exp=3b", d); end
    for (int i = 0; i < 4; i++) begin
      src_i = 4'($urandom);
      tick();
      checks++; if ({io_oe[2], io_out[2]} !== 2'b10) begin failures++; $display("FAIL pt_src7 got=%b exp=10", {io_oe[2], io_out[2]}); end
    end
  endtask

  task automatic test_open_drain;
    bus_write(A_MODE, 16'd1, 8'h04);
    src_i[0] = 1'b0;
    tick();
    checks++; if ({io_oe[1], io_out[1]} !== 2'b10) begin failures++; $display("FAIL od_low got=%b exp=10", {io_oe[1], io_out[1]}); end
    src_i[0] = 1'b1;
    tick();
    checks++; if ({io_oe[1], io_out[1]} !== 2'b00) begin failures++; $display("FAIL od_high got=%b exp=00", {io_oe[1], io_out[1]}); end
  endtask

  task automatic test_random_modes;
    logic [7:0] exp_mode [8];
    logic [1:0] e;
    logic [7:0] d;
    int c;
    for (int it = 0; it < 20; it++) begin
      for (int ch = 0; ch < 8; ch++) begin
        exp_mode[ch] = 8'($urandom);
        bus_write(A_MODE, 16'(ch), exp_mode[ch]);
      end
      src_i = 4'($urandom);
      tick();
      for (int ch = 0; ch < 8; ch++) begin
        e = pad_model(exp_mode[ch], src_i);
        checks++; if ({io_oe[ch], io_out[ch]} !== e) begin failures++; $display("FAIL rand_pad it=%0d ch=%0d mode=%h src=%h got=%b exp=%b", it, ch, exp_mode[ch], src_i, {io_oe[ch], io_out[ch]}, e); end
      end
      c = int'($urandom_range(7, 0));
      bus_read(A_MODE, 16'(c), d);
      checks++; if (d !== (exp_mode[c] & 8'h3F)) begin failures++; $display("FAIL rand_mode_rd ch=%0d got=%h exp=%h", c, d, exp_mode[c] & 8'h3F); end
    end
  endtask

  task automatic test_edges;
    logic [7:0] d;
    logic [7:0] exp_flags;
    logic [7:0] nv;
    logic [7:0] m;
    io_in[5] = 1'b1;
    tick(); tick();
    bus_read(A_EDGE, 16'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL edge_early got=%h exp=00", d); end
    tick();
    bus_read(A_EDGE, 16'd0, d);
    checks++; if (d !== 8'h20) begin failures++; $display("FAIL edge_set got=%h exp=20", d); end
    checks++; if (edge_any !== 1'b1) begin failures++; $display("FAIL edge_any_set got=%b exp=1", edge_any); end
    bus_write(A_EDGE, 16'd0, 8'h20);
    bus_read(A_EDGE, 16'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL edge_clear got=%h exp=00", d); end
    checks++; if (edge_any !== 1'b0) begin failures++; $display("FAIL edge_any_clear got=%b exp=0", edge_any); end
    io_in[5] = 1'b0;
    tick(); tick();
    bus_write(A_EDGE, 16'd0, 8'h20);
    bus_read(A_EDGE, 16'd0, d);
    checks++; if (d !== 8'h20) begin failures++; $display("FAIL edge_set_wins got=%h exp=20", d); end
    checks++; if (edge_any !== 1'b1) begin failures++; $display("FAIL edge_any_set_wins got=%b exp=1", edge_any); end
    exp_flags = 8'h20;
    for (int it = 0; it < 10; it++) begin
      nv = 8'($urandom);
      exp_flags = exp_flags | (nv ^ io_in);
      io_in = nv;
      repeat (3) tick();
      bus_read(A_STATE, 16'd0, d);
      checks++; if (d !== nv) begin failures++; $display("FAIL sync_state got=%h exp=%h", d, nv); end
      bus_read(A_EDGE, 16'd0, d);
      checks++; if (d !== exp_flags) begin failures++; $display("FAIL rand_flags got=%h exp=%h", d, exp_flags); end
      m = 8'($urandom);
      bus_write(A_EDGE, 16'd0, m);
      exp_flags = exp_flags & ~m;
      bus_read(A_EDGE, 16'd0, d);
      checks++; if (d !== exp_flags) begin failures++; $display("FAIL rand_clear got=%h exp=%h", d, exp_flags); end
      checks++; if (edge_any !== (|exp_flags)) begin failures++; $display("FAIL rand_edge_any got=%b exp=%b", edge_any, |exp_flags); end
    end
  endtask

  task automatic test_fsm_abort;
    logic [7:0] d;
    logic [1:0] exp_st;
    power_down();
    bus_write(A_PWR, 16'd0, 8'h01);
    bus_read(A_PWR, 16'd0, d);
    checks++; if (d[2:1] !== 2'd1) begin failures++; $display("FAIL abort_onwait got=%0d exp=1", d[2:1]); end
    bus_write(A_PWR, 16'd0, 8'h00);
    bus_read(A_PWR, 16'd0, d);
    checks++; if (d[2:1] !== 2'd0) begin failures++; $display("FAIL abort_off got=%0d exp=0", d[2:1]); end
    checks++; if (target_npower !== 1'b1) begin failures++; $display("FAIL abort_npower got=%b exp=1", target_npower); end
    power_up();
    bus_write(A_PWR, 16'd0, 8'h00);
    bus_write(A_PWR, 16'd0, 8'h01);
    for (int k = 2; k <= D + 3; k++) begin
      if (k > 2) tick();
      exp_st = (k <= D) ? 2'd3 : ((k == D + 1) ? 2'd0 : 2'd1);
      bus_read(A_PWR, 16'd0, d);
      checks++; if (d !== {5'b00000, exp_st, 1'b1}) begin failures++; $display("FAIL offwait_seq k=%0d got=%h exp=%h", k, d, {5'b00000, exp_st, 1'b1}); end
      checks++; if (target_npower !== (exp_st == 2'd0)) begin failures++; $display("FAIL offwait_npower k=%0d got=%b exp=%b", k, target_npower, exp_st == 2'd0); end
    end
  endtask

  task automatic test_bus_misc;
    logic [7:0] d;
    logic [5:0] hq [5];
    logic [15:0] hl [5];
    hq[0] = A_MODE;  hl[0] = 16'd8;
    hq[1] = A_STATE; hl[1] = 16'd1;
    hq[2] = A_EDGE;  hl[2] = 16'd1;
    hq[3] = A_PWR;   hl[3] = 16'd1;
    hq[4] = 6'd3;    hl[4] = 16'd0;
    for (int i = 0; i < 5; i++) begin
      reg_hypaddress = hq[i];
      #1;
      checks++; if (reg_hyplen !== hl[i]) begin failures++; $display("FAIL hyplen addr=%0d got=%0d exp=%0d", hq[i], reg_hyplen, hl[i]); end
    end
    bus_write(A_MODE, 16'd0, 8'h2A);
    bus_write(A_MODE, 16'd8, 8'h11);
    bus_read(A_MODE, 16'd0, d);
    checks++; if (d !== 8'h2A) begin failures++; $display("FAIL oor_write got=%h exp=2a", d); end
    bus_read(A_MODE, 16'd8, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL oor_mode_rd got=%h exp=00", d); end
    bus_read(A_EDGE, 16'd1, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL oor_edge_rd got=%h exp=00", d); end
    bus_read(6'd10, 16'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL unaddr_rd got=%h exp=00", d); end
    reg_address = A_MODE;
    reg_bytecnt = 16'd0;
    reg_read = 1'b1;
    reg_addrvalid = 1'b0;
    #1;
    checks++; if (reg_datao !== 8'h00) begin failures++; $display("FAIL noaddrvalid_rd got=%h exp=00", reg_datao); end
    reg_read = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    reg_address = 6'd0;
    reg_bytecnt = 16'd0;
    reg_datai = 8'h00;
    reg_read = 1'b0;
    reg_write = 1'b0;
    reg_addrvalid = 1'b0;
    reg_hypaddress = 6'd0;
    src_i = 4'h0;
    io_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_reset_mid_on();
    test_power();
    test_passthru();
    test_open_drain();
    test_random_modes();
    test_edges();
    test_fsm_abort();
    test_bus_misc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
